// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bus for alu_pipe.
// master = operand sequencer / result sink side, slave = the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, zero, neg, ovf
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, result, zero, neg, ovf
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage stallable signed ALU with persistent accumulator.
// Stage 1 captures the operand beat, stage 2 computes and registers the
// result and flags. A single advance enable stalls both stages together.
// Build option: define ALU_SAT_EN to saturate accumulator overflow instead
// of wrapping modulo 2^(WIDTH+1).
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_NOT_A = 3'b010,
    OP_ROR_B = 3'b011,
    OP_AND   = 3'b100,
    OP_XOR   = 3'b101,
    OP_ACC   = 3'b110,
    OP_CLR   = 3'b111
  } op_t;

  // pipeline advance: everything moves unless a result is stuck at the output
  logic en;

  // stage 1
  logic             s1_valid_reg;
  op_t              s1_op_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;

  // stage 2 / output
  logic           out_valid_reg;
  logic [WIDTH:0] result_reg;
  logic           zero_reg;
  logic           neg_reg;
  logic           ovf_reg;

  // accumulator
  logic signed [WIDTH:0] acc_reg;

  // stage-2 combinational datapath
  logic signed [WIDTH:0]   sa;
  logic signed [WIDTH:0]   sb;
  logic signed [WIDTH:0]   res_next;
  logic signed [WIDTH:0]   acc_next;
  logic        [WIDTH+1:0] acc_sum;
  logic                    acc_ovf;
  logic                    ovf_next;
  logic                    acc_we;

  assign en           = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = en;

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.neg       = neg_reg;
  assign bus.ovf       = ovf_reg;

  assign sa = {s1_a_reg[WIDTH-1], s1_a_reg};
  assign sb = {s1_b_reg[WIDTH-1], s1_b_reg};

  // one extra bit of headroom so the true ACC sum is exact; overflow is a
  // disagreement between the two top bits
  assign acc_sum = {acc_reg[WIDTH], acc_reg} + {sa[WIDTH], sa};
  assign acc_ovf = acc_sum[WIDTH+1] ^ acc_sum[WIDTH];

  // stage 1: capture the operand beat on an accepting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= OP_ADD;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
    end else if (en) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op_reg <= op_t'(bus.opcode);
        s1_a_reg  <= bus.a;
        s1_b_reg  <= bus.b;
      end
    end
  end

  // stage 2 datapath: result, overflow and accumulator update per opcode
  always_comb begin
    res_next = '0;
    ovf_next = 1'b0;
    acc_next = acc_reg;
    acc_we   = 1'b0;
    case (s1_op_reg)
      OP_ADD:   res_next = sa + sb;
      OP_SUB:   res_next = sa - sb;
      OP_NOT_A: res_next = ~sa;
      OP_ROR_B: res_next = {{WIDTH{1'b0}}, |s1_b_reg};
      OP_AND:   res_next = sa & sb;
      OP_XOR:   res_next = sa ^ sb;
      OP_ACC: begin
        acc_we   = 1'b1;
        ovf_next = acc_ovf;
`ifdef ALU_SAT_EN
        // clamp toward the sign of the true sum
        if (acc_ovf) begin
          acc_next = acc_sum[WIDTH+1] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, {WIDTH{1'b1}}};
        end else begin
          acc_next = acc_sum[WIDTH:0];
        end
`else
        // dropping the headroom bit wraps modulo 2^(WIDTH+1)
        acc_next = acc_sum[WIDTH:0];
`endif
        res_next = acc_next;
      end
      OP_CLR: begin
        acc_we   = 1'b1;
        acc_next = '0;
        res_next = '0;
      end
      default: ;
    endcase
  end

  // stage 2 registers: bubbles clear out_valid but leave result, flags and acc alone
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      neg_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (en) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg <= res_next;
        zero_reg   <= (res_next == '0);
        neg_reg    <= res_next[WIDTH];
        ovf_reg    <= ovf_next;
      end
    end
  end

  // accumulator: only a valid ACC/CLR beat leaving stage 1 changes it, so
  // back-to-back ACC beats each see the previous update without bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (en && s1_valid_reg && acc_we) begin
      acc_reg <= acc_next;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe against a
// transaction-level reference model (integer arithmetic + FIFO of
// expected results, acc tracked in acceptance order).
module tb_alu_pipe;
  localparam int W    = 4;
  localparam int RW   = W + 1;
  localparam int MAXV = (2 ** W) - 1;
  localparam int MINV = -(2 ** W);
  localparam int MOD  = 2 ** (W + 1);

  typedef struct {
    logic [W:0] res;
    logic       zero;
    logic       neg;
    logic       ovf;
  } exp_t;

  logic clk;
  logic reset;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_m = 0;
  exp_t q[$];
  logic [W:0] drain_res[$];
  logic       drain_ovf[$];
  bit   accepted;
  bit   drained;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: each accepted beat computed from the opcode rules in plain integers
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   sa;
    int   sb;
    int   r;
    int   s;
    bit   o;
    sa = $signed(av);
    sb = $signed(bv);
    r  = 0;
    o  = 1'b0;
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = -sa - 1;
      3'd3: r = (bv != 0) ? 1 : 0;
      3'd4: r = sa & sb;
      3'd5: r = sa ^ sb;
      3'd6: begin
        s = acc_m + sa;
        if (s > MAXV || s < MINV) begin
          o = 1'b1;
`ifdef ALU_SAT_EN
          s = (s > MAXV) ? MAXV : MINV;
`else
          s = (s > MAXV) ? s - MOD : s + MOD;
`endif
        end
        acc_m = s;
        r     = s;
      end
      default: begin
        acc_m = 0;
        r     = 0;
      end
    endcase
    e.res  = RW'(r);
    e.zero = (r == 0);
    e.neg  = (r < 0);
    e.ovf  = o;
    return e;
  endfunction

  // one clock: observe at negedge (scoreboard), then step past the rising edge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    drained  = 1'b0;
    if (reset) begin
      q.delete();
      acc_m = 0;
    end else begin
      chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", bus.out_valid, 1'b0);
        end else begin
          e = q[0];
          chk("result", bus.result, e.res);
          chk("zero", bus.zero, e.zero);
          chk("neg", bus.neg, e.neg);
          chk("ovf", bus.ovf, e.ovf);
          if (bus.out_ready) begin
            void'(q.pop_front());
            drain_res.push_back(bus.result);
            drain_ovf.push_back(bus.ovf);
            drained = 1'b1;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.opcode, bus.a, bus.b));
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // single beat into an empty pipeline; checks latency and explicit result
  task automatic run_one(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W:0] er, input logic eo);
    int k;
    bit done;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.a         = av;
    bus.b         = bv;
    k    = 0;
    done = 1'b0;
    while (!done && k < 8) begin
      cycle();
      done = accepted;
      k++;
    end
    chk({tag, "_accept"}, done, 1'b1);
    bus.in_valid = 1'b0;
    drain_res.delete();
    drain_ovf.delete();
    k    = 0;
    done = 1'b0;
    while (!done && k < 8) begin
      cycle();
      k++;
      done = drained;
    end
    chk({tag, "_drained"}, done, 1'b1);
    chk({tag, "_latency"}, k, 2);
    if (done) begin
      chk({tag, "_res"}, drain_res[0], er);
      chk({tag, "_ovf"}, drain_ovf[0], eo);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] acc3_exp;
    int idx;
    int n0;

    // reset
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.opcode    = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, 0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_zero", bus.zero, 1'b0);
    chk("rst_neg", bus.neg, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    reset = 1'b0;
    cycle();

    // directed opcodes
    run_one("add_7_7",   3'd0, 4'd7,     4'd7,     5'b01110, 1'b0);
    chk("add_7_7_zero", bus.zero, 1'b0);
    chk("add_7_7_neg", bus.neg, 1'b0);
    run_one("sub_m8_7",  3'd1, 4'b1000,  4'd7,     5'b10001, 1'b0);
    chk("sub_m8_7_neg", bus.neg, 1'b1);
    run_one("not_a",     3'd2, 4'b0101,  4'd0,     5'b11010, 1'b0);
    run_one("ror_b0",    3'd3, 4'd3,     4'd0,     5'b00000, 1'b0);
    chk("ror_b0_zero", bus.zero, 1'b1);
    run_one("ror_b4",    3'd3, 4'd0,     4'b0100,  5'b00001, 1'b0);
    run_one("and",       3'd4, 4'b1111,  4'b0101,  5'b00101, 1'b0);
    run_one("xor",       3'd5, 4'b1111,  4'b0101,  5'b11010, 1'b0);
    run_one("clr",       3'd7, 4'd5,     4'd5,     5'b00000, 1'b0);

    // ACC x3 back-to-back
`ifdef ALU_SAT_EN
    acc3_exp = 5'd15;
`else
    acc3_exp = 5'b10101;
`endif
    drain_res.delete();
    drain_ovf.delete();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.opcode   = 3'd6;
      bus.a        = 4'd7;
      bus.b        = 4'd0;
      cycle();
      chk("acc_b2b_accept", accepted, 1'b1);
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8 && drain_res.size() < 3; k++) cycle();
    chk("acc_b2b_count", drain_res.size(), 3);
    if (drain_res.size() == 3) begin
      chk("acc_b2b_res0", drain_res[0], 5'd7);
      chk("acc_b2b_res1", drain_res[1], 5'd14);
      chk("acc_b2b_res2", drain_res[2], acc3_exp);
      chk("acc_b2b_ovf1", drain_ovf[1], 1'b0);
      chk("acc_b2b_ovf2", drain_ovf[2], 1'b1);
    end

    // backpressure: 4 ADD beats, out_ready low for the first 6 cycles
    drain_res.delete();
    drain_ovf.delete();
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      bus.out_ready = (c >= 6);
      bus.in_valid  = (idx < 4);
      bus.opcode    = 3'd0;
      bus.a         = 4'(idx + 1);
      bus.b         = 4'(idx);
      if (c == 4) begin
        chk("bp_in_ready_low", bus.in_ready, 1'b0);
        chk("bp_out_valid_held", bus.out_valid, 1'b1);
      end
      cycle();
      if (accepted) idx++;
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", idx, 4);
    chk("bp_drained", drain_res.size(), 4);
    if (drain_res.size() == 4) begin
      chk("bp_res0", drain_res[0], 5'd1);
      chk("bp_res1", drain_res[1], 5'd3);
      chk("bp_res2", drain_res[2], 5'd5);
      chk("bp_res3", drain_res[3], 5'd7);
    end

    // reset mid-stream
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.opcode    = 3'd6;
    bus.a         = 4'd5;
    bus.b         = 4'd0;
    cycle();
    chk("rst_mid_accept", accepted, 1'b1);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    cycle();
    chk("rst_mid_out_valid", bus.out_valid, 1'b0);
    chk("rst_mid_in_ready", bus.in_ready, 1'b1);
    reset = 1'b0;
    cycle();
    chk("rst_mid_still_idle", bus.out_valid, 1'b0);
    run_one("acc_after_rst", 3'd6, 4'd3, 4'd0, 5'd3, 1'b0);

    // random stream with random backpressure
    n0 = 0;
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.opcode    = 3'($urandom);
      bus.a         = 4'($urandom);
      bus.b         = 4'($urandom);
      cycle();
      if (drained) n0++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    chk("rand_queue_empty", q.size(), 0);
    chk("rand_final_idle", bus.out_valid, 1'b0);
    $display("random phase drained %0d beats", n0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
